// File: rtl/spline_scan_sequencer.sv
// Walks the scan grid in raster order, kicking the interpolation engine once per point and
// forwarding each (x, y, peak_idx) result downstream over a valid/ready handshake.
module spline_scan_sequencer #(
  parameter int unsigned POINT_NUM_X = 240,
  parameter int unsigned POINT_NUM_Y = 220,
  parameter int unsigned IDX_W       = 32,
  parameter int unsigned TIMEOUT     = 4096,
  localparam int unsigned XW = (POINT_NUM_X > 1) ? $clog2(POINT_NUM_X) : 1,
  localparam int unsigned YW = (POINT_NUM_Y > 1) ? $clog2(POINT_NUM_Y) : 1,
  localparam int unsigned CW = $clog2(POINT_NUM_X * POINT_NUM_Y + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             scan_start,
  input  logic             scan_abort,
  output logic             busy,
  output logic             scan_done,
  output logic             err_timeout,
  output logic             interp_start,
  output logic [XW-1:0]    interp_x,
  output logic [YW-1:0]    interp_y,
  input  logic             interp_done,
  input  logic [IDX_W-1:0] interp_peak_idx,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
  output logic [IDX_W-1:0] out_peak_idx,
  output logic [CW-1:0]    point_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [XW-1:0] XLast = XW'(POINT_NUM_X - 1);
  localparam logic [YW-1:0] YLast = YW'(POINT_NUM_Y - 1);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]  peak_q, peak_d;
  logic              err_q, err_d;
  logic              x_last, y_last;

  assign x_last = (x_q == XLast);
  assign y_last = (y_q == YLast);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      peak_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      peak_q  <= peak_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    peak_d  = peak_q;
    err_d   = err_q;
    // Abort drops straight to idle; counters and the sticky error are left for inspection.
    if (scan_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scan_start) begin
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StIssue;
          end
        end
        StIssue: begin
          timer_d = '0;
          state_d = StWait;
        end
        StWait: begin
          if (interp_done) begin
            peak_d  = interp_peak_idx;
            state_d = StEmit;
          end else if (timer_q == TLast) begin
            peak_d  = '1;
            err_d   = 1'b1;
            state_d = StEmit;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        StEmit: begin
          if (out_rdy) begin
            cnt_d = cnt_q + CW'(1);
            // Coordinates stay on the last point once the scan completes.
            if (x_last && y_last) begin
              state_d = StDone;
            end else begin
              if (x_last) begin
                x_d = '0;
                y_d = y_q + YW'(1);
              end else begin
                x_d = x_q + XW'(1);
              end
              state_d = StIssue;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign busy         = (state_q == StIssue) || (state_q == StWait) || (state_q == StEmit);
  assign scan_done    = (state_q == StDone);
  assign err_timeout  = err_q;
  assign interp_start = (state_q == StIssue);
  assign interp_x     = x_q;
  assign interp_y     = y_q;
  assign out_vld      = (state_q == StEmit);
  assign out_x        = x_q;
  assign out_y        = y_q;
  assign out_peak_idx = peak_q;
  assign point_cnt    = cnt_q;

endmodule
